mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter MIN_WAIT, default 2: clock cycles MOC is ignored after MOV rises (masks stale MOC=1).
REQ-002 SHALL have parameter TIMEOUT, default 64: cycles allowed per RAM access before a timeout error.
REQ-003 SHALL have ports: Clk  in  1  single clock, all state on rising edge; Reset  in  1  synchronous, active-high.
REQ-004 CPU side: Start  in  1  request strobe; OpCode  in  6  MIPS load/store opcode; Addr  in  9  byte address; WrData  in  64  store data ([63:32] first word of a doubleword, [31:0] otherwise).
REQ-005 CPU side: RdData  out  64  load result; Done  out  1  one-cycle completion pulse; Busy  out  1  request in progress; Err  out  1  error flag, valid with Done; ErrCode  out  2  01 misaligned, 10 bad opcode, 11 timeout.
REQ-006 RAM side: MOV  out  1; ReadWrite  out  1  1=read 0=write; RamAddr  out  9; RamDataIn  out  32  to RAM DataIn; RamOpCode  out  6; RamDataOut  in  32  from RAM DataOut; MOC  in  1  asynchronous completion.

Function
REQ-007 SHALL accept Start only in IDLE, latching OpCode, Addr, WrData; Start while Busy ignored.
REQ-008 Reads: 100000, 100001, 100011, 100100, 100101, 110101 (doubleword); writes: 101000, 101001, 101011, 111111 (doubleword); ReadWrite derived from OpCode.
REQ-009 Any other OpCode -> no RAM access, Done with Err=1, ErrCode=10, two cycles after Start.
REQ-010 Alignment: halfword needs Addr[0]=0, word Addr[1:0]=0, doubleword Addr[2:0]=0; violation -> no RAM access, Done with Err=1, ErrCode=01, two cycles after Start; bad opcode takes priority.
REQ-011 MOC SHALL pass through a 2-flop synchronizer before use.
REQ-012 States: IDLE, CHECK, ISSUE, WAIT, GAP, FIN.
REQ-013 IDLE->CHECK on Start; CHECK->FIN on error, else ->ISSUE.
REQ-014 ISSUE: drive RamAddr, RamOpCode, ReadWrite, RamDataIn, then MOV=1 one cycle later (address/data stable one cycle before MOV rises); ->WAIT.
REQ-015 WAIT: hold MOV=1; ignore synced MOC for MIN_WAIT cycles, then on synced MOC=1 capture RamDataOut (reads), drop MOV, ->GAP.
REQ-016 GAP: MOV=0 for 2 cycles minimum; then ->ISSUE if second doubleword phase pending, else ->FIN.
REQ-017 Doubleword: exactly two MOV pulses, same RamAddr and RamOpCode both phases; write phase 1 RamDataIn=WrData[63:32], phase 2 =WrData[31:0]; read RdData={phase-1 data, phase-2 data}.
REQ-018 Single reads: RdData={32'h0, captured word}; writes leave RdData unchanged.
REQ-019 Timeout counter reset on each MOV rise; reaching TIMEOUT in WAIT -> MOV=0, abandon remaining phases, ->FIN with Err=1, ErrCode=11.
REQ-020 FIN: Done=1 for exactly one cycle, Busy=0 next cycle, ->IDLE; Start in the FIN cycle ignored.
REQ-021 Busy=1 from cycle after Start acceptance through FIN inclusive.
REQ-022 MOV SHALL never rise twice without at least 2 cycles low between.

Reset
REQ-023 Reset SHALL force IDLE, MOV=0, Done=0, Busy=0, Err=0, ErrCode=00, RdData=0, RamAddr=0, RamOpCode=0, RamDataIn=0, ReadWrite=1, synchronizer flops=0, counters=0.
REQ-024 Reset mid-operation SHALL drop MOV on next edge and discard the request; no Done pulse.
REQ-025 Reset outranks Start in the same cycle.

Verification
REQ-026 Word store OpCode=101011, Addr=0x010, WrData[31:0]=0xDEADBEEF, then word load 100011 same Addr -> RdData=0x00000000DEADBEEF, Err=0, one MOV pulse each.
REQ-027 Doubleword store 111111, Addr=0x020, WrData=0x0123456789ABCDEF, then load 110101 -> RdData=0x0123456789ABCDEF, exactly two MOV pulses per request, MOV low >=2 cycles between.
REQ-028 Load word 100011 at Addr=0x012 -> Done with Err=1, ErrCode=01, MOV never rises; OpCode=000000 -> ErrCode=10.
REQ-029 MOC model tied low, TIMEOUT=64 -> MOV falls and Done with ErrCode=11 64 cycles after MOV rise.
REQ-030 Reset asserted in WAIT of a word store -> MOV=0 and Busy=0 next edge, no Done; following signed byte load 100000 of 0x80 at Addr=0x030 completes with RdData=0x00000000FFFFFF80.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Bridges a single-request CPU load/store port onto an asynchronous RAM
// handshake (MOV/MOC). The request is latched on Start, checked for a legal
// MIPS load/store opcode and natural alignment, then issued as one RAM access
// (two for doubleword opcodes). Completion, with or without an error, is
// reported by a one-cycle Done pulse.
//
// Handshakes:
//   CPU side : Start is sampled only while idle; the request (OpCode, Addr,
//              WrData) is captured on that edge and may change afterwards.
//              Busy is high from the next cycle until the Done cycle
//              inclusive. Done pulses once; Err/ErrCode/RdData are valid
//              while Done is high.
//   RAM side : RamAddr, RamOpCode, ReadWrite and RamDataIn become valid one
//              cycle before MOV rises and stay stable while MOV is high. The
//              RAM answers by raising MOC (asynchronous). MOC is synchronized;
//              RamDataOut is sampled once the synchronized MOC is seen, so it
//              has been stable for at least two cycles. MOV then drops and
//              stays low for at least two cycles before any further rise.
//
// Parameters:
//   MIN_WAIT   cycles after MOV rises during which synchronized MOC is ignored
//   TIMEOUT    cycles allowed per RAM access before a timeout error
//
// Ports:
//   Clk, Reset                     clock, synchronous active-high reset
//   Start, OpCode, Addr, WrData    CPU request
//   RdData, Done, Busy, Err,
//   ErrCode                        CPU response (01 misaligned, 10 bad
//                                  opcode, 11 timeout)
//   MOV, ReadWrite, RamAddr,
//   RamDataIn, RamOpCode           RAM request (ReadWrite 1 = read)
//   RamDataOut, MOC                RAM response
//   DbgState                       current controller state, for debug
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
   parameter int MIN_WAIT = 2,
   parameter int TIMEOUT  = 64
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic [5:0]  OpCode,
   input  logic [8:0]  Addr,
   input  logic [63:0] WrData,
   output logic [63:0] RdData,
   output logic        Done,
   output logic        Busy,
   output logic        Err,
   output logic [1:0]  ErrCode,
   output logic        MOV,
   output logic        ReadWrite,
   output logic [8:0]  RamAddr,
   output logic [31:0] RamDataIn,
   output logic [5:0]  RamOpCode,
   input  logic [31:0] RamDataOut,
   input  logic        MOC,
   output logic [2:0]  DbgState
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_GAP   = 3'd4,
      S_FIN   = 3'd5
   } state_t;

   // One counter serves both the WAIT (mask + timeout) and GAP phases.
   localparam int CNT_MAX = (TIMEOUT > MIN_WAIT) ? TIMEOUT : MIN_WAIT;
   localparam int CW      = $clog2(CNT_MAX + 2);
   localparam logic [CW-1:0] MIN_WAIT_C = CW'(MIN_WAIT);
   localparam logic [CW-1:0] TO_LAST_C  = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] GAP_LAST_C = CW'(1);

   state_t        state_q;
   logic [5:0]    op_q;
   logic [8:0]    addr_q;
   logic [63:0]   wdata_q;
   logic [63:0]   rd_buf_q;
   logic          phase2_q;
   logic          moc_meta_q;
   logic          moc_sync_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Decode of the latched request
   logic op_ok;
   logic op_read;
   logic op_dw;
   logic align_bad;

   always_comb begin
      op_ok     = 1'b1;
      op_read   = 1'b1;
      op_dw     = 1'b0;
      align_bad = 1'b0;
      case (op_q)
         6'b100000, 6'b100100: align_bad = 1'b0;             // byte loads
         6'b100001, 6'b100101: align_bad = addr_q[0];        // halfword loads
         6'b100011:            align_bad = |addr_q[1:0];     // word load
         6'b110101: begin                                     // doubleword load
            op_dw     = 1'b1;
            align_bad = |addr_q[2:0];
         end
         6'b101000: op_read = 1'b0;                           // byte store
         6'b101001: begin                                     // halfword store
            op_read   = 1'b0;
            align_bad = addr_q[0];
         end
         6'b101011: begin                                     // word store
            op_read   = 1'b0;
            align_bad = |addr_q[1:0];
         end
         6'b111111: begin                                     // doubleword store
            op_read   = 1'b0;
            op_dw     = 1'b1;
            align_bad = |addr_q[2:0];
         end
         default:   op_ok = 1'b0;
      endcase
   end

   assign cnt_d    = cnt_q + CW'(1);
   assign DbgState = state_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_buf_q   <= '0;
         phase2_q   <= 1'b0;
         moc_meta_q <= 1'b0;
         moc_sync_q <= 1'b0;
         cnt_q      <= '0;
         RdData     <= '0;
         Done       <= 1'b0;
         Busy       <= 1'b0;
         Err        <= 1'b0;
         ErrCode    <= 2'b00;
         MOV        <= 1'b0;
         ReadWrite  <= 1'b1;
         RamAddr    <= '0;
         RamDataIn  <= '0;
         RamOpCode  <= '0;
      end else begin
         moc_meta_q <= MOC;
         moc_sync_q <= moc_meta_q;
         Done       <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (Start) begin
                  op_q    <= OpCode;
                  addr_q  <= Addr;
                  wdata_q <= WrData;
                  Busy    <= 1'b1;
                  Err     <= 1'b0;
                  ErrCode <= 2'b00;
                  state_q <= S_CHECK;
               end
            end

            S_CHECK: begin
               // Bad opcode is reported ahead of misalignment.
               if (!op_ok) begin
                  Err     <= 1'b1;
                  ErrCode <= 2'b10;
                  Done    <= 1'b1;
                  state_q <= S_FIN;
               end else if (align_bad) begin
                  Err     <= 1'b1;
                  ErrCode <= 2'b01;
                  Done    <= 1'b1;
                  state_q <= S_FIN;
               end else begin
                  RamAddr   <= addr_q;
                  RamOpCode <= op_q;
                  ReadWrite <= op_read;
                  RamDataIn <= op_dw ? wdata_q[63:32] : wdata_q[31:0];
                  phase2_q  <= 1'b0;
                  rd_buf_q  <= '0;
                  state_q   <= S_ISSUE;
               end
            end

            // RAM bus was set up on entry; MOV follows one cycle later.
            S_ISSUE: begin
               MOV     <= 1'b1;
               cnt_q   <= '0;
               state_q <= S_WAIT;
            end

            S_WAIT: begin
               // The MIN_WAIT mask hides a MOC still high from the previous
               // access working its way through the synchronizer.
               if (moc_sync_q && (cnt_q >= MIN_WAIT_C)) begin
                  if (op_read) begin
                     if (op_dw && !phase2_q) rd_buf_q[63:32] <= RamDataOut;
                     else                    rd_buf_q[31:0]  <= RamDataOut;
                  end
                  MOV     <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= S_GAP;
               end else if (cnt_q == TO_LAST_C) begin
                  // Any pending doubleword phase is abandoned.
                  MOV     <= 1'b0;
                  Err     <= 1'b1;
                  ErrCode <= 2'b11;
                  Done    <= 1'b1;
                  state_q <= S_FIN;
               end else begin
                  cnt_q <= cnt_d;
               end
            end

            S_GAP: begin
               if (cnt_q == GAP_LAST_C) begin
                  cnt_q <= '0;
                  if (op_dw && !phase2_q) begin
                     phase2_q  <= 1'b1;
                     RamDataIn <= wdata_q[31:0];
                     state_q   <= S_ISSUE;
                  end else begin
                     if (op_read) RdData <= rd_buf_q;
                     Done    <= 1'b1;
                     state_q <= S_FIN;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end

            S_FIN: begin
               Busy    <= 1'b0;
               state_q <= S_IDLE;
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Bench for mem_access_ctrl: a byte-addressed RAM model answering MOV with an
// asynchronous MOC after a random delay, a bus monitor, a directed vector
// table, hand-written corner sequences (timeout, reset mid-access, Start
// while busy, reset versus Start) and a randomized phase predicted by a
// transaction-level reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_access_ctrl;

   localparam int MIN_WAIT = 2;
   localparam int TIMEOUT  = 64;

   // ---------------- clock / reset / DUT ----------------
   logic        Clk = 1'b0;
   logic        Reset;
   logic        Start;
   logic [5:0]  OpCode;
   logic [8:0]  Addr;
   logic [63:0] WrData;
   logic [63:0] RdData;
   logic        Done;
   logic        Busy;
   logic        Err;
   logic [1:0]  ErrCode;
   logic        MOV;
   logic        ReadWrite;
   logic [8:0]  RamAddr;
   logic [31:0] RamDataIn;
   logic [5:0]  RamOpCode;
   logic [31:0] RamDataOut;
   logic        MOC;
   logic [2:0]  DbgState;

   mem_access_ctrl #(.MIN_WAIT(MIN_WAIT), .TIMEOUT(TIMEOUT)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .OpCode(OpCode), .Addr(Addr),
      .WrData(WrData), .RdData(RdData), .Done(Done), .Busy(Busy), .Err(Err),
      .ErrCode(ErrCode), .MOV(MOV), .ReadWrite(ReadWrite), .RamAddr(RamAddr),
      .RamDataIn(RamDataIn), .RamOpCode(RamOpCode), .RamDataOut(RamDataOut),
      .MOC(MOC), .DbgState(DbgState)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard counters ----------------
   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   logic [7:0]  ref_mem [512];
   logic [63:0] last_rd;

   function automatic int op_size(input logic [5:0] op);
      case (op)
         6'b100000, 6'b100100, 6'b101000: return 1;
         6'b100001, 6'b100101, 6'b101001: return 2;
         6'b100011, 6'b101011:            return 4;
         6'b110101, 6'b111111:            return 8;
         default:                         return 0;
      endcase
   endfunction

   function automatic bit op_read(input logic [5:0] op);
      return op inside {6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b110101};
   endfunction

   // expv = {err, errcode[1:0], pulses[1:0], rddata[63:0]}
   task automatic ref_txn(input logic [5:0] op, input logic [8:0] addr,
                          input logic [63:0] wd, output logic [68:0] expv);
      int          sz;
      int          p;
      logic        e;
      logic [1:0]  c;
      logic [63:0] v;
      logic [8:0]  ai;
      sz = op_size(op);
      e  = 1'b0;
      c  = 2'b00;
      p  = 0;
      if (sz == 0) begin
         e = 1'b1;
         c = 2'b10;
      end else if ((int'(addr) % sz) != 0) begin
         e = 1'b1;
         c = 2'b01;
      end else begin
         p = (sz == 8) ? 2 : 1;
         if (op_read(op)) begin
            v = '0;
            for (int i = 0; i < sz; i++) begin
               ai = addr + 9'(i);
               v  = (v << 8) | 64'(ref_mem[ai]);
            end
            if (op == 6'b100000)      v = {32'h0, {24{v[7]}}, v[7:0]};
            else if (op == 6'b100001) v = {32'h0, {16{v[15]}}, v[15:0]};
            last_rd = v;
         end else begin
            for (int i = 0; i < sz; i++) begin
               ai          = addr + 9'(i);
               ref_mem[ai] = wd[8*(sz-1-i) +: 8];
            end
         end
      end
      expv = {e, c, 2'(p), last_rd};
   endtask

   // ---------------- RAM model ----------------
   logic [7:0] ram [512];
   bit         moc_enable = 1'b1;
   bit         dw_phase   = 1'b0;
   bit         pending    = 1'b0;
   bit         served     = 1'b0;
   int         delay      = 0;

   task automatic ram_access();
      logic [8:0] a;
      a = RamAddr;
      if (RamOpCode == 6'b110101 || RamOpCode == 6'b111111) begin
         if (dw_phase) a = a + 9'd4;
         dw_phase = !dw_phase;
      end
      case (RamOpCode)
         6'b100000: RamDataOut = {{24{ram[a][7]}}, ram[a]};
         6'b100100: RamDataOut = {24'h0, ram[a]};
         6'b100001: RamDataOut = {{16{ram[a][7]}}, ram[a], ram[a+9'd1]};
         6'b100101: RamDataOut = {16'h0, ram[a], ram[a+9'd1]};
         6'b100011, 6'b110101:
            RamDataOut = {ram[a], ram[a+9'd1], ram[a+9'd2], ram[a+9'd3]};
         6'b101000: ram[a] = RamDataIn[7:0];
         6'b101001: begin
            ram[a]      = RamDataIn[15:8];
            ram[a+9'd1] = RamDataIn[7:0];
         end
         6'b101011, 6'b111111: begin
            ram[a]      = RamDataIn[31:24];
            ram[a+9'd1] = RamDataIn[23:16];
            ram[a+9'd2] = RamDataIn[15:8];
            ram[a+9'd3] = RamDataIn[7:0];
         end
         default: ;
      endcase
   endtask

   initial begin
      MOC        = 1'b0;
      RamDataOut = '0;
      forever begin
         @(negedge Clk);
         if (!Busy) dw_phase = 1'b0;
         if (!MOV) begin
            pending = 1'b0;
            served  = 1'b0;
            if (MOC) begin
               #2;
               MOC = 1'b0;
            end
         end else if (!served) begin
            if (!pending) begin
               pending = 1'b1;
               delay   = $urandom_range(0, 6);
            end
            if (delay == 0) begin
               pending = 1'b0;
               served  = 1'b1;
               if (moc_enable) begin
                  ram_access();
                  #2;
                  MOC = 1'b1;
               end
            end else begin
               delay--;
            end
         end
      end
   end

   // ---------------- RAM bus monitor ----------------
   int          mov_rises = 0;
   int          rise_cyc  = 0;
   int          low_run   = 99;
   logic        mov_prev  = 1'b0;
   logic [47:0] prev_bus  = '0;
   logic [5:0]  cur_op    = '0;
   logic        cur_rw    = 1'b1;

   always begin
      @(posedge Clk);
      #1;
      if (Reset) begin
         mov_prev = 1'b0;
         low_run  = 99;
      end else begin
         if (MOV && !mov_prev) begin
            mov_rises++;
            rise_cyc = cyc;
            check("mov_low_gap", 64'(low_run >= 2), 64'd1);
            check("ram_bus_setup", 64'(prev_bus),
                  64'({RamAddr, RamOpCode, ReadWrite, RamDataIn}));
            check("ram_opcode", 64'(RamOpCode), 64'(cur_op));
            check("ram_readwrite", 64'(ReadWrite), 64'(cur_rw));
         end
         low_run  = MOV ? 0 : low_run + 1;
         mov_prev = MOV;
      end
      prev_bus = {RamAddr, RamOpCode, ReadWrite, RamDataIn};
   end

   // ---------------- driver tasks ----------------
   int   done_cyc;
   logic mov_at_done;

   task automatic do_req(input logic [5:0] op, input logic [8:0] addr,
                         input logic [63:0] wd, output logic [68:0] got_v,
                         output int lat);
      int   n;
      logic busy_ok;
      cur_op = op;
      cur_rw = op_read(op);
      @(negedge Clk);
      mov_rises = 0;
      Start  = 1'b1;
      OpCode = op;
      Addr   = addr;
      WrData = wd;
      @(negedge Clk);
      // Scramble the request lines: the DUT must work from its latched copy.
      Start   = 1'b0;
      OpCode  = 6'($urandom);
      Addr    = 9'($urandom);
      WrData  = {$urandom, $urandom};
      n       = 1;
      busy_ok = Busy;
      while (!Done && n < 300) begin
         @(negedge Clk);
         n++;
         busy_ok = busy_ok & Busy;
      end
      check("done_seen", 64'(Done), 64'd1);
      lat         = n;
      done_cyc    = cyc;
      mov_at_done = MOV;
      got_v       = {Err, ErrCode, 2'(mov_rises), RdData};
      check("busy_held", 64'(busy_ok), 64'd1);
      @(negedge Clk);
      check("done_one_cycle", 64'(Done), 64'd0);
      check("busy_after_fin", 64'(Busy), 64'd0);
   endtask

   task automatic txn_check(input string nm, input logic [5:0] op, input logic [8:0] addr,
                            input logic [63:0] wd, input logic [68:0] expv);
      logic [68:0] got;
      int          lat;
      do_req(op, addr, wd, got, lat);
      check({nm, "_err"},     64'(got[68]),    64'(expv[68]));
      check({nm, "_errcode"}, 64'(got[67:66]), 64'(expv[67:66]));
      check({nm, "_pulses"},  64'(got[65:64]), 64'(expv[65:64]));
      check({nm, "_rddata"},  got[63:0],       expv[63:0]);
      if (expv[68] && expv[67:66] != 2'b11)
         check({nm, "_err_latency"}, 64'(lat), 64'd2);
   endtask

   task automatic check_reset_vals(input string nm);
      check({nm, "_mov"},     64'(MOV),       64'd0);
      check({nm, "_busy"},    64'(Busy),      64'd0);
      check({nm, "_done"},    64'(Done),      64'd0);
      check({nm, "_err"},     64'(Err),       64'd0);
      check({nm, "_errcode"}, 64'(ErrCode),   64'd0);
      check({nm, "_rddata"},  RdData,         64'd0);
      check({nm, "_ramaddr"}, 64'(RamAddr),   64'd0);
      check({nm, "_ramop"},   64'(RamOpCode), 64'd0);
      check({nm, "_ramdin"},  64'(RamDataIn), 64'd0);
      check({nm, "_rw"},      64'(ReadWrite), 64'd1);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [5:0]  op;
      logic [8:0]  addr;
      logic [63:0] wd;
      logic        err;
      logic [1:0]  code;
      int          pulses;
      logic [63:0] rd;
   } vec_t;

   localparam int NV = 16;
   vec_t tbl [NV];

   logic [5:0]  ops [10];
   logic [68:0] exp_q [$];

   // ---------------- main sequence ----------------
   initial begin
      logic [68:0] expv;
      logic [68:0] dummy;
      logic [68:0] got;
      int          lat;
      int          n;
      bit          seen;

      tbl[0]  = '{6'b101011, 9'h010, 64'h00000000DEADBEEF, 1'b0, 2'b00, 1, 64'h0};
      tbl[1]  = '{6'b100011, 9'h010, 64'h0, 1'b0, 2'b00, 1, 64'h00000000DEADBEEF};
      tbl[2]  = '{6'b111111, 9'h020, 64'h0123456789ABCDEF, 1'b0, 2'b00, 2, 64'h00000000DEADBEEF};
      tbl[3]  = '{6'b110101, 9'h020, 64'h0, 1'b0, 2'b00, 2, 64'h0123456789ABCDEF};
      tbl[4]  = '{6'b100011, 9'h012, 64'h0, 1'b1, 2'b01, 0, 64'h0123456789ABCDEF};
      tbl[5]  = '{6'b000000, 9'h010, 64'h0, 1'b1, 2'b10, 0, 64'h0123456789ABCDEF};
      tbl[6]  = '{6'b101001, 9'h013, 64'h1234, 1'b1, 2'b01, 0, 64'h0123456789ABCDEF};
      tbl[7]  = '{6'b111111, 9'h024, 64'h1, 1'b1, 2'b01, 0, 64'h0123456789ABCDEF};
      tbl[8]  = '{6'b000000, 9'h013, 64'h0, 1'b1, 2'b10, 0, 64'h0123456789ABCDEF};
      tbl[9]  = '{6'b101000, 9'h030, 64'h80, 1'b0, 2'b00, 1, 64'h0123456789ABCDEF};
      tbl[10] = '{6'b100100, 9'h030, 64'h0, 1'b0, 2'b00, 1, 64'h0000000000000080};
      tbl[11] = '{6'b101001, 9'h040, 64'h8001, 1'b0, 2'b00, 1, 64'h0000000000000080};
      tbl[12] = '{6'b100001, 9'h040, 64'h0, 1'b0, 2'b00, 1, 64'h00000000FFFF8001};
      tbl[13] = '{6'b100101, 9'h040, 64'h0, 1'b0, 2'b00, 1, 64'h0000000000008001};
      tbl[14] = '{6'b100011, 9'h040, 64'h0, 1'b0, 2'b00, 1, 64'h0000000080010000};
      tbl[15] = '{6'b110101, 9'h01C, 64'h0, 1'b1, 2'b01, 0, 64'h0000000080010000};

      ops = '{6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
              6'b110101, 6'b101000, 6'b101001, 6'b101011, 6'b111111};

      for (int i = 0; i < 512; i++) begin
         ram[i]     = 8'h00;
         ref_mem[i] = 8'h00;
      end
      last_rd = '0;

      Reset  = 1'b1;
      Start  = 1'b0;
      OpCode = '0;
      Addr   = '0;
      WrData = '0;
      repeat (3) @(negedge Clk);
      check_reset_vals("reset");
      Reset = 1'b0;
      @(negedge Clk);
      check_reset_vals("idle_after_reset");

      // Directed table
      for (int i = 0; i < NV; i++) begin
         ref_txn(tbl[i].op, tbl[i].addr, tbl[i].wd, dummy);
         txn_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].wd,
                   {tbl[i].err, tbl[i].code, 2'(tbl[i].pulses), tbl[i].rd});
      end

      // Start held high while busy and through the Done cycle is ignored.
      ref_txn(6'b100011, 9'h010, 64'h0, dummy);
      cur_op = 6'b100011;
      cur_rw = 1'b1;
      @(negedge Clk);
      mov_rises = 0;
      Start  = 1'b1;
      OpCode = 6'b100011;
      Addr   = 9'h010;
      @(negedge Clk);
      OpCode = 6'b000000;
      Addr   = 9'h013;
      n = 1;
      while (!Done && n < 300) begin
         @(negedge Clk);
         n++;
      end
      check("hold_start_done", 64'(Done), 64'd1);
      check("hold_start_rddata", RdData, 64'h00000000DEADBEEF);
      check("hold_start_err", 64'(Err), 64'd0);
      check("hold_start_pulses", 64'(mov_rises), 64'd1);
      @(negedge Clk);
      Start = 1'b0;
      check("start_in_fin_ignored", 64'(Busy), 64'd0);
      @(negedge Clk);
      check("still_idle", 64'(Busy), 64'd0);

      // Reset outranks Start in the same cycle.
      Reset  = 1'b1;
      Start  = 1'b1;
      OpCode = 6'b100011;
      Addr   = 9'h010;
      @(negedge Clk);
      Reset = 1'b0;
      Start = 1'b0;
      check_reset_vals("reset_vs_start");
      last_rd = '0;
      @(negedge Clk);
      check("reset_vs_start_idle", 64'(Busy), 64'd0);

      // Reset while a word store waits for MOC.
      moc_enable = 1'b0;
      cur_op = 6'b101011;
      cur_rw = 1'b0;
      @(negedge Clk);
      Start  = 1'b1;
      OpCode = 6'b101011;
      Addr   = 9'h060;
      WrData = 64'h11223344;
      @(negedge Clk);
      Start = 1'b0;
      n = 0;
      while (!MOV && n < 20) begin
         @(negedge Clk);
         n++;
      end
      check("rst_wait_mov_up", 64'(MOV), 64'd1);
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      check("rst_wait_mov", 64'(MOV), 64'd0);
      check("rst_wait_busy", 64'(Busy), 64'd0);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         seen = seen | Done;
         @(negedge Clk);
      end
      check("rst_wait_no_done", 64'(seen), 64'd0);
      moc_enable = 1'b1;
      last_rd = '0;
      ref_txn(6'b100000, 9'h030, 64'h0, dummy);
      txn_check("lb_after_reset", 6'b100000, 9'h030, 64'h0,
                {1'b0, 2'b00, 2'd1, 64'h00000000FFFFFF80});

      // Timeouts: the RAM never answers.
      moc_enable = 1'b0;
      do_req(6'b100011, 9'h100, 64'h0, got, lat);
      check("to_word_err", 64'(got[68]), 64'd1);
      check("to_word_code", 64'(got[67:66]), 64'd3);
      check("to_word_pulses", 64'(got[65:64]), 64'd1);
      check("to_word_rddata", got[63:0], last_rd);
      check("to_word_delay", 64'(done_cyc - rise_cyc), 64'(TIMEOUT));
      check("to_word_mov_low", 64'(mov_at_done), 64'd0);
      do_req(6'b111111, 9'h108, 64'hA5A5A5A5_5A5A5A5A, got, lat);
      check("to_dw_code", 64'(got[67:66]), 64'd3);
      check("to_dw_pulses", 64'(got[65:64]), 64'd1);
      check("to_dw_delay", 64'(done_cyc - rise_cyc), 64'(TIMEOUT));
      moc_enable = 1'b1;

      // Randomized phase against the reference model.
      for (int i = 0; i < 40; i++) begin
         logic [5:0]  op;
         logic [8:0]  a;
         logic [63:0] wd;
         int          k;
         k  = $urandom_range(0, 11);
         op = (k < 10) ? ops[k] : 6'($urandom);
         a  = 9'($urandom_range(0, 511));
         if ($urandom_range(0, 9) < 7) a = a & 9'h1F8;
         wd = {$urandom, $urandom};
         ref_txn(op, a, wd, expv);
         exp_q.push_back(expv);
         do_req(op, a, wd, got, lat);
         expv = exp_q.pop_front();
         check($sformatf("rnd%0d_op%b_a%h", i, op, a), 64'(got[68:64]), 64'(expv[68:64]));
         check($sformatf("rnd%0d_rddata", i), got[63:0], expv[63:0]);
         if (expv[68])
            check($sformatf("rnd%0d_err_latency", i), 64'(lat), 64'd2);
      end

      repeat (3) @(negedge Clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
